// File: rtl/hash_table_pkg.sv
// Shared hash-table command/result payload types and client identifiers.
package hash_table;

    localparam int unsigned HT_KEY_W = 32;
    localparam int unsigned HT_VAL_W = 32;

    typedef enum logic [1:0] {
        HT_OP_LOOKUP = 2'd0,
        HT_OP_INSERT = 2'd1,
        HT_OP_DELETE = 2'd2,
        HT_OP_NOP    = 2'd3
    } ht_opcode_e;

    typedef enum logic [1:0] {
        HT_ST_OK        = 2'd0,
        HT_ST_NOT_FOUND = 2'd1,
        HT_ST_FULL      = 2'd2,
        HT_ST_ERR       = 2'd3
    } ht_status_e;

    typedef struct packed {
        ht_opcode_e            opcode;
        logic [HT_KEY_W-1:0]   key;
        logic [HT_VAL_W-1:0]   value;
    } ht_command_t;

    typedef struct packed {
        ht_status_e            status;
        logic [HT_VAL_W-1:0]   value;
    } ht_result_t;

    typedef enum logic {
        CLIENT_A = 1'b0,
        CLIENT_B = 1'b1
    } ht_client_id_t;

    function automatic ht_client_id_t other_client(input ht_client_id_t id);
        return (id == CLIENT_A) ? CLIENT_B : CLIENT_A;
    endfunction

endpackage

// File: rtl/ht_id_fifo.sv
// In-flight issuer-ID FIFO; full/empty derive from the occupancy count.
module ht_id_fifo
    import hash_table::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  ht_client_id_t    push_id_i,
    input  logic             pop_i,
    output ht_client_id_t    head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    ht_client_id_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(DEPTH));
        w_pop   = pop_i && !w_empty;
        w_push  = push_i && (!w_full || w_pop);
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_id_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign count_o = r_count;

endmodule

// File: rtl/ht_cmd_arb.sv
// Two-client round-robin front end for hash_table_top with in-order result steering.
// Define HT_CMD_ARB_STAT_EN to add per-client issue counters and an in-flight high-watermark.
module ht_cmd_arb
    import hash_table::*;
#(
    parameter  int unsigned INFLIGHT_DEPTH = 16,
    localparam int unsigned CNT_W          = $clog2(INFLIGHT_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  ht_command_t      a_cmd_i,
    input  logic             a_cmd_valid_i,
    output logic             a_cmd_ready_o,
    input  ht_command_t      b_cmd_i,
    input  logic             b_cmd_valid_i,
    output logic             b_cmd_ready_o,
    output ht_command_t      ht_cmd_o,
    output logic             ht_cmd_valid_o,
    input  logic             ht_cmd_ready_i,
    input  ht_result_t       ht_res_i,
    input  logic             ht_res_valid_i,
    output logic             ht_res_ready_o,
    output ht_result_t       a_res_o,
    output logic             a_res_valid_o,
    input  logic             a_res_ready_i,
    output ht_result_t       b_res_o,
    output logic             b_res_valid_o,
    input  logic             b_res_ready_i,
    output logic [CNT_W-1:0] inflight_o,
    output logic             orphan_err_o
`ifdef HT_CMD_ARB_STAT_EN
    ,
    output logic [31:0]      a_issued_o,
    output logic [31:0]      b_issued_o,
    output logic [CNT_W-1:0] inflight_max_o
`endif
);

    localparam int unsigned SUM_W = CNT_W + 1;

    ht_command_t      r_cmd;
    logic             r_cmd_valid;
    ht_client_id_t    r_last;
    logic             r_orphan;

    logic             w_slot_free;
    logic             w_room;
    logic             w_load;
    ht_client_id_t    w_pick;
    ht_client_id_t    w_head;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;

    // Grant uses the registered count, so a pop frees room one cycle later.
    always_comb begin
        w_slot_free = !r_cmd_valid || ht_cmd_ready_i;
        w_room      = ({1'b0, w_count} + SUM_W'(r_cmd_valid)) < SUM_W'(INFLIGHT_DEPTH);
        if (a_cmd_valid_i && b_cmd_valid_i) begin
            w_pick = other_client(r_last);
        end else begin
            w_pick = b_cmd_valid_i ? CLIENT_B : CLIENT_A;
        end
        w_load        = w_slot_free && w_room && !w_fifo_full && (a_cmd_valid_i || b_cmd_valid_i);
        a_cmd_ready_o = w_load && (w_pick == CLIENT_A);
        b_cmd_ready_o = w_load && (w_pick == CLIENT_B);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_last      <= CLIENT_B;
        end else if (w_load) begin
            r_cmd       <= (w_pick == CLIENT_A) ? a_cmd_i : b_cmd_i;
            r_cmd_valid <= 1'b1;
            r_last      <= w_pick;
        end else if (ht_cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
        end
    end

    // Results come back in issue order; the FIFO head names the destination.
    always_comb begin
        a_res_o        = ht_res_i;
        b_res_o        = ht_res_i;
        a_res_valid_o  = ht_res_valid_i && !w_fifo_empty && (w_head == CLIENT_A);
        b_res_valid_o  = ht_res_valid_i && !w_fifo_empty && (w_head == CLIENT_B);
        ht_res_ready_o = w_fifo_empty ? 1'b1
                       : ((w_head == CLIENT_A) ? a_res_ready_i : b_res_ready_i);
        w_pop          = ht_res_valid_i && ht_res_ready_o && !w_fifo_empty;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_orphan <= 1'b0;
        end else if (ht_res_valid_i && w_fifo_empty) begin
            r_orphan <= 1'b1;
        end
    end

    ht_id_fifo #(
        .DEPTH (INFLIGHT_DEPTH)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push_i    (w_load),
        .push_id_i (w_pick),
        .pop_i     (w_pop),
        .head_o    (w_head),
        .empty_o   (w_fifo_empty),
        .full_o    (w_fifo_full),
        .count_o   (w_count)
    );

    assign ht_cmd_o       = r_cmd;
    assign ht_cmd_valid_o = r_cmd_valid;
    assign inflight_o     = w_count;
    assign orphan_err_o   = r_orphan;

`ifdef HT_CMD_ARB_STAT_EN
    logic [31:0]      r_a_issued;
    logic [31:0]      r_b_issued;
    logic [CNT_W-1:0] r_inflight_max;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_a_issued     <= '0;
            r_b_issued     <= '0;
            r_inflight_max <= '0;
        end else begin
            if (a_cmd_ready_o) r_a_issued <= r_a_issued + 32'd1;
            if (b_cmd_ready_o) r_b_issued <= r_b_issued + 32'd1;
            if (w_count > r_inflight_max) r_inflight_max <= w_count;
        end
    end

    assign a_issued_o     = r_a_issued;
    assign b_issued_o     = r_b_issued;
    assign inflight_max_o = r_inflight_max;
`endif

endmodule
